// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the two-master memory port arbiter: FSM state
// encodings, requester ids and the default memory geometry (32 x 9).
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 9;

  // Requester ids; id 0 is the processor path, id 1 the switch/IO loader.
  localparam logic REQ_PROC = 1'b0;
  localparam logic REQ_IO   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//   req0, req1   : pending requests
//   last_grant   : id of the requester served most recently
//   grant_valid  : at least one request is pending
//   grant_id     : winning requester; on a tie the one not served last wins
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = REQ_PROC;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = REQ_IO;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between the processor (requester
// 0) and the switch/IO program loader (requester 1). One access is in flight
// at a time: IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> RESP -> IDLE.
// All outputs are registered.
//
// Ports
//   Clock, Resetn            : clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN    : requester N level request and its fields
//   ackN                     : one-cycle completion pulse for requester N
//   rdata                    : read data, valid with ack of a read; holds
//   mem_addr/mem_wdata/mem_wren/mem_q : memory side
//   busy                     : FSM not in IDLE
//
// RD_LAT must be in 1..3 (wait counter is two bits wide).
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic          mwren_q, mwren_d;
  logic          busy_q, busy_d;

  logic          grant_valid;
  logic          grant_id;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwren_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          // The memory address/data registers double as the latched request
          // fields: they are loaded at grant and held until the next grant.
          id_d     = grant_id;
          we_d     = grant_id ? we1    : we0;
          maddr_d  = grant_id ? addr1  : addr0;
          mwdata_d = grant_id ? wdata1 : wdata0;
          mwren_d  = grant_id ? we1    : we0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          ack0_d  = (id_q == REQ_PROC);
          ack1_d  = (id_q == REQ_IO);
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_q;
          ack0_d  = (id_q == REQ_PROC);
          ack1_d  = (id_q == REQ_IO);
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        last_d  = id_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      id_q     <= REQ_PROC;
      we_q     <= 1'b0;
      cnt_q    <= 2'd0;
      last_q   <= REQ_IO;  // requester 0 wins the first tie
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwren_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwren_q  <= mwren_d;
      busy_q   <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign mem_wren  = mwren_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 32x9 data/instruction memory between two masters:
  - Requester 0: the processor's ADDR/DOUT/W path.
  - Requester 1: the switch/IO loader that preloads programs.
- Accepts one request at a time and sequences the memory access, including the synchronous read latency.
- Returns read data with a one-cycle acknowledge.
- Uses round-robin arbitration so neither master can starve the other.

Parameters:
- AW, 5, memory address width.
- DW, 9, data word width (matches bus width).
- RD_LAT, 1, memory read latency in clock cycles, legal range 1..3.

Ports:
- Clock  in  1  system clock, all state updates on posedge.
- Resetn  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 access request, level.
- we0  in  1  requester 0 write enable (1=write, 0=read).
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- ack0  out  1  requester 0 completion pulse.
- req1  in  1  requester 1 access request, level.
- we1  in  1  requester 1 write enable.
- addr1  in  AW  requester 1 address.
- wdata1  in  DW  requester 1 write data.
- ack1  out  1  requester 1 completion pulse.
- rdata  out  DW  read data, valid in the cycle ack is high for a read.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wren  out  1  memory write strobe.
- mem_q  in  DW  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock (Clock); asynchronous active-low reset (Resetn). All outputs are registered.
- Reset values:
  - state=IDLE.
  - ack0=ack1=0, rdata=0, mem_addr=0, mem_wdata=0, mem_wren=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On grant, latch id, we, addr and wdata of the winner, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr = latched addr; mem_wdata = latched wdata; mem_wren = latched we.
  - Write: go to RESP.
  - Read: load wait counter with RD_LAT-1, then go to WAIT.
- WAIT:
  - mem_wren=0 and mem_addr is held.
  - Counter decrements each cycle.
  - When the counter reaches 0, capture mem_q into rdata and go to RESP.
  - With RD_LAT=1, WAIT lasts exactly 1 cycle.
- RESP (1 cycle):
  - ack[id]=1 and the other ack is 0.
  - Update last_grant=id, then go to IDLE.
- Latency, with req sampled in IDLE at edge t:
  - Write: ack high in cycle t+2.
  - Read: ack high in cycle t+2+RD_LAT.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until it sees ack.
  - A req still high in the IDLE cycle after ack is treated as a new request.
  - Field changes while a request is not granted are allowed; the arbiter latches fields only at grant.
- Arbitration:
  - Requests arriving during ISSUE/WAIT/RESP are not lost; they are evaluated in the next IDLE.
  - With continuous contention, grants alternate 0,1,0,1.
- rdata:
  - Holds its last captured value between reads.
  - Is not modified by writes.
- Reset mid-operation:
  - Aborts immediately and no ack is issued.
  - mem_wren clears asynchronously; a write caught in ISSUE is not guaranteed to commit.
- Minimum request spacing: one IDLE cycle between successive accesses, so no back-to-back issue.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP (2-bit).
  - Requester ids REQ_PROC=0 and REQ_IO=1.
  - Default widths AW=5, DW=9.
- One sub-module, rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_id.
- FSM, latches, wait counter and output registers stay in mem_port_arbiter.

Test Plan:
- Reset and single write, RD_LAT=1:
  - Stimulus: Resetn low then high; req0=1, we0=1, addr0=5, wdata0=9'h1A5.
  - Required: mem_wren=1 for exactly one cycle with mem_addr=5 and mem_wdata=9'h1A5; ack0 pulse 2 cycles after grant; ack1 stays 0.
- Single read:
  - Stimulus: memory model preloaded addr 5=9'h0C3; req1=1, we1=0, addr1=5.
  - Required: ack1 at t+3 with rdata=9'h0C3; mem_wren stays 0 throughout.
- Simultaneous requests:
  - Stimulus: req0 and req1 rise together, right after reset; both held high for 4 transactions.
  - Required: grant order 0,1,0,1; each ack lands on the correct port.
- Request during busy:
  - Stimulus: req1 rises while requester 0's read is in WAIT.
  - Required: requester 1 is granted in the following IDLE, and its ack follows.
- RD_LAT=3 read:
  - Stimulus: read of addr 31 holding 9'h1FF.
  - Required: ack at t+5 with rdata=9'h1FF; mem_addr stable at 31 during ISSUE and all WAIT cycles.
- Reset mid-operation:
  - Stimulus: assert Resetn=0 during WAIT.
  - Required: no ack; outputs return immediately to reset values; busy=0; after release, the first tie goes to requester 0.
